// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: handshake and data bundle between the control FSM
// (master) and the shift sequencer (slave).
//   start        request from control, sampled by the sequencer in IDLE/DONE
//   op           shift opcode (SLL/SRL/SRA/SLLV/SRAV/LUI, 110/111 reserved)
//   shamt_field  instruction shift-amount field
//   reg_b        register B value, low 5 bits give the variable amount
//   operand      value to shift
//   result       shifted value, held until the next accepted start
//   busy         high while shifting
//   done         one-cycle completion pulse
//   amt_src      latched amount source: 00 shamt, 01 LUI constant, 10 reg_b
interface shift_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [4:0]        shamt_field;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] result;
    logic              busy;
    logic              done;
    logic [1:0]        amt_src;

    modport master (
        output start, op, shamt_field, reg_b, operand,
        input  result, busy, done, amt_src
    );

    modport slave (
        input  start, op, shamt_field, reg_b, operand,
        output result, busy, done, amt_src
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter for SLL/SRL/SRA/SLLV/SRAV/LUI.
// Loads the operand on an accepted start, shifts it one bit per clock
// (or up to four bits per clock when SHIFT_FAST_EN is defined), then
// pulses done for one cycle and holds the result.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    shift_sequencer_if.slave (start/op/amount sources in,
//          result/busy/done/amt_src out)
// Optional build macro: SHIFT_FAST_EN (multi-bit steps, up to 4 per edge).
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | shifting result, counter counts down remaining bits
// DONE   | done pulse; start here is accepted back-to-back
module shift_sequencer #(
    parameter int DATA_W  = 32,
    parameter int LUI_AMT = 16
) (
    input  logic                clk,
    input  logic                reset,
    shift_sequencer_if.slave    bus
);
    localparam logic [4:0] LUI_N = 5'(LUI_AMT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [4:0]        count;
    logic [DATA_W-1:0] result_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        amt_src_q;

    logic [4:0]        amt_n;
    logic [1:0]        src_n;
    logic [4:0]        step;
    logic [DATA_W-1:0] shifted;

    // Upper reg_b bits never contribute to the amount.
    logic unused_reg_b;
    assign unused_reg_b = ^bus.reg_b[DATA_W-1:5];

    always_comb begin
        amt_n = 5'd0;
        src_n = 2'b00;
        case (bus.op)
            3'b000, 3'b001, 3'b010: begin
                amt_n = bus.shamt_field;
                src_n = 2'b00;
            end
            3'b011, 3'b100: begin
                amt_n = bus.reg_b[4:0];
                src_n = 2'b10;
            end
            3'b101: begin
                amt_n = LUI_N;
                src_n = 2'b01;
            end
            default: begin
                // Reserved ops pass the operand through with no shift.
                amt_n = 5'd0;
                src_n = 2'b00;
            end
        endcase
    end

`ifdef SHIFT_FAST_EN
    assign step = (count > 5'd4) ? 5'd4 : count;
`else
    assign step = 5'd1;
`endif

    always_comb begin
        shifted = result_q;
        case (op_q)
            3'b000, 3'b011, 3'b101: shifted = result_q << step;
            3'b010, 3'b100:         shifted = DATA_W'($signed(result_q) >>> step);
            3'b001:                 shifted = result_q >> step;
            default:                shifted = result_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= 3'b000;
            count     <= 5'd0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            amt_src_q <= 2'b00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q      <= bus.op;
                        result_q  <= bus.operand;
                        count     <= amt_n;
                        amt_src_q <= src_n;
                        if (amt_n == 5'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= SHIFT;
                            busy_q <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    result_q <= shifted;
                    count    <= count - step;
                    if (count == step) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result  = result_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.amt_src = amt_src_q;
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller for the CPU's shift path; executes SLL/SRL/SRA/SLLV/SRAV/LUI one bit per cycle.
- Internally selects the shift amount from one of three sources: instruction shamt field, constant 16, or register B.
- Sequences load → shift → done and holds the result for the control unit.
- Sits between the control FSM (start/done handshake) and the ALU-out/writeback mux.

Parameters:
DATA_W, 32, operand/result width
LUI_AMT, 16, fixed amount for LUI

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE or DONE
op  in  3  000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRAV, 101 LUI, 110/111 reserved
shamt_field  in  5  instruction bits [10:6]
reg_b  in  DATA_W  register B value; low 5 bits are the variable amount
operand  in  DATA_W  value to shift
result  out  DATA_W  shifted value, held until next accepted start
busy  out  1  high in SHIFT
done  out  1  one-cycle pulse in DONE
amt_src  out  2  latched amount source: 00 shamt_field, 01 LUI_AMT, 10 reg_b[4:0]

Behaviour:
- Reset (async, any state): state=IDLE, result=0, counter=0, busy=0, done=0, amt_src=00.
- States: IDLE, SHIFT, DONE.
- Accept:
  - start=1 at a rising edge while in IDLE or DONE latches op, operand→result, and amount N→counter.
  - amt_src is set from op: SLL/SRL/SRA→00, LUI→01, SLLV/SRAV→10.
- Next state after accept: N=0 → DONE; else → SHIFT.
- SHIFT, each edge:
  - Shift result by 1 bit. SLL/SLLV/LUI: left, fill 0. SRL: right, fill 0. SRA/SRAV: right, fill result[DATA_W-1].
  - Decrement counter. When counter reaches 0 on that edge → DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: IDLE, or re-accept if start=1 (back-to-back supported).
- Latency: start at edge 0 → done high in the cycle after edge max(N,0); N=0 gives done in the cycle after edge 0.
- start while busy: ignored, no queuing; op, operand and reg_b changes during SHIFT have no effect.
- Reserved op (110/111): N forced to 0, result=operand, done after 1 cycle, amt_src=00.
- Amount width: only reg_b[4:0] is used; upper bits are ignored (amount 0x23 → 3).
- Reset mid-SHIFT: immediate return to IDLE, partial result discarded (result=0).

Optional Feature:
SHIFT_FAST_EN
- Defined: each SHIFT edge shifts by min(4, counter) bits and subtracts the same from counter. Latency becomes ceil(N/4) edges; fill and sign rules are unchanged.
- Undefined: 1 bit per edge, as above.

Test Plan:
- op=010 SRA, operand=0x80000000, shamt_field=4 → busy edges 1-3, result=0xF8000000, done in cycle after edge 4, amt_src=00.
- op=011 SLLV, operand=0x00000001, reg_b=0x00000023 → amount 3, result=0x00000008, done after edge 3, amt_src=10.
- op=101 LUI, operand=0x00001234 → result=0x12340000, done after edge 16 (edge 4 with SHIFT_FAST_EN), amt_src=01.
- op=001 SRL, shamt_field=0, operand=0xDEADBEEF → no SHIFT state, result=0xDEADBEEF, done after edge 0.
- SRL by 8 on 0xFF000000; pulse start with new op at edge 2; assert reset at edge 5 → second start ignored, reset gives result=0, busy=0, done=0, IDLE.
- Back-to-back: start held high in DONE with SLL by 1 on 0x00000001 → re-accepted, second done one edge later with result=0x00000002.
